// File: rtl/crossbar_4x4_bg_arbiter_pkg.sv
// Shared widths and helpers for the 4x4 LSU <-> bank-group crossbar sequencer.
package crossbar_4x4_bg_arbiter_pkg;

  localparam int N_PORT       = 4;
  localparam int SEL_W        = 2;
  localparam int READ_LAT_DEF = 2;

  typedef logic [SEL_W-1:0] idx_t;

  // Target bank group of LSU i from the packed lsu_bg bus.
  function automatic idx_t bg_of(input logic [N_PORT*SEL_W-1:0] bg, input int i);
    return bg[i*SEL_W +: SEL_W];
  endfunction

endpackage

// File: rtl/crossbar_4x4_bg_arbiter_rr_arb4.sv
// Four-way round-robin pick: first requester at or after ptr, wrapping mod 4.
module rr_arb4
  import crossbar_4x4_bg_arbiter_pkg::*;
(
  input  logic [N_PORT-1:0] req,
  input  idx_t              ptr,
  output logic [N_PORT-1:0] grant,
  output idx_t              winner,
  output logic              any
);

  idx_t cand;

  // Walk offsets from farthest to nearest so the closest requester wins last.
  always_comb begin
    cand   = '0;
    winner = ptr;
    any    = 1'b0;
    for (int k = N_PORT - 1; k >= 0; k--) begin
      cand = ptr + idx_t'(k);
      if (req[cand]) begin
        winner = cand;
        any    = 1'b1;
      end
    end
    grant = any ? (N_PORT'(1) << winner) : '0;
  end

endmodule

// File: rtl/crossbar_4x4_bg_arbiter.sv
// Per-BG round-robin arbitration, registered crossbar controls and read-return steering.
// Handshake: lsu_grant[i] is a same-cycle ready; a request transfers on a cycle with lsu_valid[i] & lsu_grant[i].
module crossbar_4x4_bg_arbiter
  import crossbar_4x4_bg_arbiter_pkg::*;
#(
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORT-1:0]         lsu_valid,
  input  logic [N_PORT-1:0]         lsu_we,
  input  logic [N_PORT*SEL_W-1:0]   lsu_bg,
  input  logic [N_PORT-1:0]         bg_stall,
  output logic [N_PORT-1:0]         lsu_grant,
  output logic [N_PORT-1:0]         bg_en_q,
  output logic [N_PORT-1:0]         bg_we_q,
  output logic [N_PORT*SEL_W-1:0]   bg_src_q,
  output logic [N_PORT-1:0]         rsp_valid_q,
  output logic [N_PORT*SEL_W-1:0]   rsp_src_q
);

  logic [N_PORT-1:0] req [N_PORT];
  logic [N_PORT-1:0] win_oh [N_PORT];
  idx_t              win_idx [N_PORT];
  logic [N_PORT-1:0] win_any;
  idx_t              ptr_q [N_PORT];
  logic              ret_v [N_PORT];
  idx_t              ret_id [N_PORT];
  logic              dup_ret;

  always_comb begin
    for (int j = 0; j < N_PORT; j++) begin
      for (int i = 0; i < N_PORT; i++) begin
        req[j][i] = ~rst & ~bg_stall[j] & lsu_valid[i] & (bg_of(lsu_bg, i) == idx_t'(j));
      end
    end
  end

  for (genvar j = 0; j < N_PORT; j++) begin : g_arb
    rr_arb4 u_arb (
      .req    (req[j]),
      .ptr    (ptr_q[j]),
      .grant  (win_oh[j]),
      .winner (win_idx[j]),
      .any    (win_any[j])
    );
  end

  // An LSU names a single BG, so at most one arbiter can pick it.
  always_comb begin
    lsu_grant = '0;
    for (int j = 0; j < N_PORT; j++) lsu_grant = lsu_grant | win_oh[j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bg_en_q  <= '0;
      bg_we_q  <= '0;
      bg_src_q <= '0;
      for (int j = 0; j < N_PORT; j++) ptr_q[j] <= '0;
    end else begin
      for (int j = 0; j < N_PORT; j++) begin
        if (win_any[j]) begin
          bg_en_q[j]                   <= 1'b1;
          bg_we_q[j]                   <= lsu_we[win_idx[j]];
          bg_src_q[j*SEL_W +: SEL_W]   <= win_idx[j];
          ptr_q[j]                     <= win_idx[j] + idx_t'(1);
        end else begin
          bg_en_q[j] <= 1'b0;
          bg_we_q[j] <= 1'b0;
        end
      end
    end
  end

  // The issue register acts as the first return stage; READ_LAT-1 more stages follow.
  for (genvar j = 0; j < N_PORT; j++) begin : g_ret
    if (READ_LAT == 1) begin : g_direct
      assign ret_v[j]  = bg_en_q[j] & ~bg_we_q[j];
      assign ret_id[j] = bg_src_q[j*SEL_W +: SEL_W];
    end else begin : g_pipe
      logic [READ_LAT-2:0] v_sr;
      idx_t                id_sr [READ_LAT-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          v_sr <= '0;
        end else begin
          v_sr[0] <= bg_en_q[j] & ~bg_we_q[j];
          for (int k = 1; k < READ_LAT - 1; k++) v_sr[k] <= v_sr[k-1];
        end
        id_sr[0] <= bg_src_q[j*SEL_W +: SEL_W];
        for (int k = 1; k < READ_LAT - 1; k++) id_sr[k] <= id_sr[k-1];
      end
      assign ret_v[j]  = v_sr[READ_LAT-2];
      assign ret_id[j] = id_sr[READ_LAT-2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_src_q   <= '0;
    end else begin
      for (int i = 0; i < N_PORT; i++) begin
        rsp_valid_q[i] <= 1'b0;
        for (int j = 0; j < N_PORT; j++) begin
          if (ret_v[j] && ret_id[j] == idx_t'(i)) begin
            rsp_valid_q[i]             <= 1'b1;
            rsp_src_q[i*SEL_W +: SEL_W] <= idx_t'(j);
          end
        end
      end
    end
  end

  always_comb begin
    dup_ret = 1'b0;
    for (int a = 0; a < N_PORT; a++) begin
      for (int b = a + 1; b < N_PORT; b++) begin
        if (ret_v[a] && ret_v[b] && ret_id[a] == ret_id[b]) dup_ret = 1'b1;
      end
    end
  end

  // Fixed latency plus one grant per LSU per cycle makes a double return impossible.
  a_no_dup_ret: assert property (@(posedge clk) disable iff (rst) !dup_ret);

endmodule

// File: tb/tb_crossbar_4x4_bg_arbiter.sv
// Directed scenarios plus randomized traffic against a round-robin reference model.
module tb_crossbar_4x4_bg_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lsu_valid, lsu_we, bg_stall;
  logic [7:0] lsu_bg;
  logic [3:0] lsu_grant, bg_en_q, bg_we_q, rsp_valid_q;
  logic [7:0] bg_src_q, rsp_src_q;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int         ptr_m [4];
  int         cyc;
  logic [3:0] exp_en, exp_we, exp_g;
  logic [7:0] exp_src, exp_rsp_src;
  logic [3:0] exp_rsp_v;
  logic [19:0] exp_q[$];   // {due_cycle[15:0], lsu[1:0], bg[1:0]}

  crossbar_4x4_bg_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .lsu_valid   (lsu_valid),
    .lsu_we      (lsu_we),
    .lsu_bg      (lsu_bg),
    .bg_stall    (bg_stall),
    .lsu_grant   (lsu_grant),
    .bg_en_q     (bg_en_q),
    .bg_we_q     (bg_we_q),
    .bg_src_q    (bg_src_q),
    .rsp_valid_q (rsp_valid_q),
    .rsp_src_q   (rsp_src_q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; lsu_valid = '0; lsu_we = '0; lsu_bg = '0; bg_stall = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Each BG picks the candidate with the smallest forward distance from its pointer.
  function automatic logic [3:0] model_grant(logic [3:0] v, logic [7:0] bg, logic [3:0] st);
    logic [3:0] g;
    int best, bestd, d;
    g = '0;
    for (int j = 0; j < 4; j++) begin
      best = -1; bestd = 99;
      if (!st[j]) begin
        for (int i = 0; i < 4; i++) begin
          if (v[i] && int'(bg[2*i +: 2]) == j) begin
            d = (i - ptr_m[j] + 4) % 4;
            if (d < bestd) begin bestd = d; best = i; end
          end
        end
      end
      if (best >= 0) g[best] = 1'b1;
    end
    return g;
  endfunction

  task automatic test_reset();
    rst = 1'b1; lsu_valid = 4'hF; lsu_we = '0; lsu_bg = 8'h00; bg_stall = '0;
    #1;
    total++; if (lsu_grant !== 4'h0) $display("FAIL reset_grant0 got %h exp 0", lsu_grant); else passed++;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (lsu_grant !== 4'h0) $display("FAIL reset_grant got %h exp 0", lsu_grant); else passed++;
      total++;
      if ({bg_en_q, bg_we_q, bg_src_q, rsp_valid_q, rsp_src_q} !== 28'h0)
        $display("FAIL reset_outputs got %h exp 0", {bg_en_q, bg_we_q, bg_src_q, rsp_valid_q, rsp_src_q});
      else passed++;
    end
    rst = 1'b0;
    #1;
    total++; if (lsu_grant !== 4'b0001) $display("FAIL reset_first_grant got %b exp 0001", lsu_grant); else passed++;
    tick();
    lsu_valid = '0;
    total++; if (bg_en_q !== 4'b0001 || bg_src_q !== 8'h00)
      $display("FAIL reset_first_issue got en=%b src=%h exp en=0001 src=00", bg_en_q, bg_src_q);
    else passed++;
  endtask

  task automatic test_no_conflict();
    do_reset();
    lsu_bg = 8'hE4; lsu_valid = 4'hF; lsu_we = 4'b1010;
    #1;
    total++; if (lsu_grant !== 4'hF) $display("FAIL noconf_grant got %h exp F", lsu_grant); else passed++;
    tick();
    lsu_valid = '0;
    total++; if (bg_en_q !== 4'hF) $display("FAIL noconf_en got %h exp F", bg_en_q); else passed++;
    total++; if (bg_src_q !== 8'hE4) $display("FAIL noconf_src got %h exp E4", bg_src_q); else passed++;
    total++; if (bg_we_q !== 4'b1010) $display("FAIL noconf_we got %b exp 1010", bg_we_q); else passed++;
    tick();
    total++; if (bg_en_q !== 4'h0 || bg_src_q !== 8'hE4)
      $display("FAIL noconf_idle got en=%h src=%h exp en=0 src=E4", bg_en_q, bg_src_q);
    else passed++;
  endtask

  task automatic test_full_conflict();
    do_reset();
    lsu_bg = 8'h55; lsu_valid = 4'hF; lsu_we = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (lsu_grant !== 4'(1 << k)) $display("FAIL conflict_grant%0d got %b exp %b", k, lsu_grant, 4'(1 << k)); else passed++;
      tick();
      total++; if (bg_en_q !== 4'b0010 || int'(bg_src_q[3:2]) != k)
        $display("FAIL conflict_src%0d got en=%b src=%0d exp en=0010 src=%0d", k, bg_en_q, bg_src_q[3:2], k);
      else passed++;
    end
    lsu_valid = '0;
  endtask

  task automatic test_read_return();
    do_reset();
    lsu_bg = 8'h30; lsu_valid = 4'b0110; lsu_we = 4'b0010;
    #1;
    total++; if (lsu_grant !== 4'b0110) $display("FAIL rd_grant got %b exp 0110", lsu_grant); else passed++;
    tick();
    lsu_valid = '0;
    total++; if (bg_en_q !== 4'b1001 || bg_we_q !== 4'b0001 || bg_src_q[7:6] !== 2'd2 || bg_src_q[1:0] !== 2'd1)
      $display("FAIL rd_issue got en=%b we=%b src=%h exp en=1001 we=0001 src[7:6]=2 src[1:0]=1", bg_en_q, bg_we_q, bg_src_q);
    else passed++;
    tick();
    total++; if (rsp_valid_q !== 4'b0000) $display("FAIL rd_early got %b exp 0000", rsp_valid_q); else passed++;
    tick();
    total++; if (rsp_valid_q !== 4'b0100 || rsp_src_q[5:4] !== 2'd3)
      $display("FAIL rd_return got v=%b src=%h exp v=0100 src[5:4]=3", rsp_valid_q, rsp_src_q);
    else passed++;
    tick();
    total++; if (rsp_valid_q !== 4'b0000 || rsp_src_q[5:4] !== 2'd3)
      $display("FAIL rd_after got v=%b src=%h exp v=0000 src[5:4]=3", rsp_valid_q, rsp_src_q);
    else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    lsu_bg = 8'h05; lsu_valid = 4'b0011; lsu_we = '0; bg_stall = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (lsu_grant !== 4'b0000) $display("FAIL stall_grant%0d got %b exp 0000", c, lsu_grant); else passed++;
      tick();
      total++; if (bg_en_q !== 4'b0000) $display("FAIL stall_en%0d got %b exp 0000", c, bg_en_q); else passed++;
    end
    bg_stall = '0;
    #1;
    total++; if (lsu_grant !== 4'b0001) $display("FAIL stall_release got %b exp 0001", lsu_grant); else passed++;
    tick();
    lsu_valid = 4'b0010;
    #1;
    total++; if (lsu_grant !== 4'b0010) $display("FAIL stall_next got %b exp 0010", lsu_grant); else passed++;
    tick();
    lsu_valid = '0;
  endtask

  task automatic test_reset_midflight();
    int seen;
    do_reset();
    lsu_bg = 8'h02; lsu_valid = 4'b0001; lsu_we = '0;
    #1;
    total++; if (lsu_grant !== 4'b0001) $display("FAIL mid_grant got %b exp 0001", lsu_grant); else passed++;
    tick();
    lsu_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rsp_valid_q !== 4'b0000) seen++;
    end
    total++; if (seen != 0) $display("FAIL mid_no_rsp got %0d responses exp 0", seen); else passed++;
  endtask

  task automatic test_random();
    logic [3:0] g_prev;
    int         j;
    do_reset();
    for (int j2 = 0; j2 < 4; j2++) ptr_m[j2] = 0;
    cyc = 0; exp_src = '0; exp_rsp_src = '0; g_prev = '0;
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      // Held requests stay put until granted; occasionally withdrawn or replaced.
      for (int i = 0; i < 4; i++) begin
        if (!(lsu_valid[i] && !g_prev[i] && $urandom_range(0, 9) != 0)) begin
          lsu_valid[i]     = ($urandom_range(0, 3) != 0);
          lsu_we[i]        = 1'($urandom_range(0, 1));
          lsu_bg[2*i +: 2] = 2'($urandom_range(0, 3));
        end
        bg_stall[i] = ($urandom_range(0, 7) == 0);
      end
      #1;
      exp_g = model_grant(lsu_valid, lsu_bg, bg_stall);
      total++; if (lsu_grant !== exp_g) $display("FAIL rnd_grant c%0d got %b exp %b", cyc, lsu_grant, exp_g); else passed++;
      exp_en = '0; exp_we = '0;
      for (int i = 0; i < 4; i++) begin
        if (exp_g[i]) begin
          j = int'(lsu_bg[2*i +: 2]);
          exp_en[j] = 1'b1;
          exp_we[j] = lsu_we[i];
          exp_src[2*j +: 2] = 2'(i);
          ptr_m[j] = (i + 1) % 4;
          if (!lsu_we[i]) exp_q.push_back({16'(cyc + 3), 2'(i), 2'(j)});
        end
      end
      g_prev = exp_g;
      tick();
      cyc++;
      exp_rsp_v = '0;
      for (int q = exp_q.size() - 1; q >= 0; q--) begin
        if (int'(exp_q[q][19:4]) == cyc) begin
          exp_rsp_v[exp_q[q][3:2]] = 1'b1;
          exp_rsp_src[2*exp_q[q][3:2] +: 2] = exp_q[q][1:0];
          exp_q.delete(q);
        end
      end
      total++; if (bg_en_q !== exp_en) $display("FAIL rnd_en c%0d got %b exp %b", cyc, bg_en_q, exp_en); else passed++;
      total++; if (bg_we_q !== exp_we) $display("FAIL rnd_we c%0d got %b exp %b", cyc, bg_we_q, exp_we); else passed++;
      total++; if (bg_src_q !== exp_src) $display("FAIL rnd_src c%0d got %h exp %h", cyc, bg_src_q, exp_src); else passed++;
      total++; if (rsp_valid_q !== exp_rsp_v) $display("FAIL rnd_rsp_v c%0d got %b exp %b", cyc, rsp_valid_q, exp_rsp_v); else passed++;
      total++; if (rsp_src_q !== exp_rsp_src) $display("FAIL rnd_rsp_src c%0d got %h exp %h", cyc, rsp_src_q, exp_rsp_src); else passed++;
    end
    lsu_valid = '0;
  endtask

  initial begin
    test_reset();
    test_no_conflict();
    test_full_conflict();
    test_read_return();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
